// File: rtl/dfi_logfetch_ctrl.sv
// Read-side sequencer for the DFI log table: walks the persistent read pointer up to a
// sampled write-pointer snapshot, one memory read at a time, and hands entries to the checker.
module dfi_logfetch_ctrl #(
    parameter int unsigned              N_ADDR_WIDTH      = 32,
    parameter int unsigned              N_DATA_WIDTH      = 32,
    parameter int unsigned              N_LOGID_WIDTH     = 8,
    parameter logic [N_ADDR_WIDTH-1:0]  LOGTABLE_ADDRINIT = 32'h1FEFFC00,
    parameter logic [N_ADDR_WIDTH-1:0]  LOGTABLE_ADDREND  = 32'h1FEFFFF8,
    parameter int unsigned              ENTRY_STRIDE      = 8,
    parameter int unsigned              TIMEOUT_CYCLES    = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_trigger,
    input  logic [N_ADDR_WIDTH-1:0]               i_logAddrptr,
    output logic                                  o_rqAccess,
    output logic [N_ADDR_WIDTH-1:0]               o_logAddr,
    input  logic                                  i_logDone,
    input  logic [N_DATA_WIDTH+N_LOGID_WIDTH-1:0] i_logData,
    output logic                                  o_entryValid,
    input  logic                                  i_entryReady,
    output logic [N_LOGID_WIDTH-1:0]              o_entryId,
    output logic [N_DATA_WIDTH-1:0]               o_entryData,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [1:0]                            o_error,
    output logic [N_ADDR_WIDTH-1:0]               o_rdPtr
);

    localparam logic [N_ADDR_WIDTH-1:0] STRIDE    = N_ADDR_WIDTH'(ENTRY_STRIDE);
    localparam logic [N_ADDR_WIDTH-1:0] ADDR_WRAP = LOGTABLE_ADDREND + STRIDE;
    localparam int unsigned             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_PRESENT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                    state_q, state_d;
    logic [N_ADDR_WIDTH-1:0]   rdptr_q, rdptr_d;
    logic [N_ADDR_WIDTH-1:0]   endptr_q, endptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_LOGID_WIDTH-1:0]  id_q, id_d;
    logic [N_DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]                err_q, err_d;

    logic [N_ADDR_WIDTH-1:0]   ptr_off;
    logic                      ptr_bad;

    // ADDREND+STRIDE is the legal "table full up to the end" pointer; it aliases ADDRINIT.
    assign ptr_off = i_logAddrptr - LOGTABLE_ADDRINIT;
    assign ptr_bad = (i_logAddrptr < LOGTABLE_ADDRINIT) || (i_logAddrptr > ADDR_WRAP) ||
                     ((ptr_off % STRIDE) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rdptr_q  <= LOGTABLE_ADDRINIT;
            endptr_q <= LOGTABLE_ADDRINIT;
            cnt_q    <= '0;
            id_q     <= '0;
            data_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdptr_q  <= rdptr_d;
            endptr_q <= endptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdptr_d  = rdptr_q;
        endptr_d = endptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_trigger) begin
                    if (ptr_bad) begin
                        err_d[1] = 1'b1;
                        state_d  = S_ERR;
                    end else begin
                        endptr_d = (i_logAddrptr == ADDR_WRAP) ? LOGTABLE_ADDRINIT : i_logAddrptr;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                cnt_d   = '0;
                state_d = (rdptr_q == endptr_q) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (i_logDone) begin
                    id_d    = i_logData[N_DATA_WIDTH +: N_LOGID_WIDTH];
                    data_d  = i_logData[N_DATA_WIDTH-1:0];
                    state_d = S_PRESENT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d[0] = 1'b1;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRESENT: begin
                if (i_entryReady) begin
                    rdptr_d = (rdptr_q == LOGTABLE_ADDREND) ? LOGTABLE_ADDRINIT : rdptr_q + STRIDE;
                    state_d = S_CHECK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rqAccess   = (state_q == S_WAIT);
    assign o_logAddr    = rdptr_q;
    assign o_entryValid = (state_q == S_PRESENT);
    assign o_entryId    = id_q;
    assign o_entryData  = data_q;
    assign o_busy       = (state_q == S_CHECK) || (state_q == S_WAIT) || (state_q == S_PRESENT);
    assign o_done       = (state_q == S_DONE);
    assign o_error      = err_q;
    assign o_rdPtr      = rdptr_q;

endmodule

// File: doc/dfi_logfetch_ctrl.md
Name: dfi_logfetch_ctrl

Overview:
- Read-side sequencer for the DFI log table in shared memory.
- On each trigger, walks the table from its persistent read pointer up to a snapshot of the software write pointer, one memory read request at a time, wrapping at the table end.
- Hands each fetched entry (log ID + data) to the dDFG checker over a valid/ready handshake.
- Flags timeouts and bad write pointers.

Parameters:
- N_ADDR_WIDTH, 32, address width.
- N_DATA_WIDTH, 32, log data width.
- N_LOGID_WIDTH, 8, log ID width.
- LOGTABLE_ADDRINIT, 32'h1FEFFC00, first entry address.
- LOGTABLE_ADDREND, 32'h1FEFFFF8, last entry address (inclusive).
- ENTRY_STRIDE, 8, bytes per entry.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_trigger  in  1  start-scan pulse.
- i_logAddrptr  in  N_ADDR_WIDTH  software write pointer (next free entry).
- o_rqAccess  out  1  memory read request.
- o_logAddr  out  N_ADDR_WIDTH  read address.
- i_logDone  in  1  read-data-valid pulse.
- i_logData  in  N_DATA_WIDTH+N_LOGID_WIDTH  {logID, data}.
- o_entryValid  out  1  entry available to checker.
- i_entryReady  in  1  checker accepts entry.
- o_entryId  out  N_LOGID_WIDTH  latched log ID.
- o_entryData  out  N_DATA_WIDTH  latched data.
- o_busy  out  1  scan in progress.
- o_done  out  1  one-cycle scan-complete pulse.
- o_error  out  2  sticky: bit0 = timeout, bit1 = bad pointer.
- o_rdPtr  out  N_ADDR_WIDTH  current read pointer.

Behaviour:
- Reset: state IDLE; rdPtr = LOGTABLE_ADDRINIT; endPtr = LOGTABLE_ADDRINIT. All outputs 0 except o_rdPtr = o_logAddr = LOGTABLE_ADDRINIT. Reset mid-scan aborts immediately; no further request is issued.
- FSM is Moore-style; outputs are decoded from the registered state and registers.
- States:
  - IDLE: on i_trigger, sample i_logAddrptr. If it is outside [ADDRINIT, ADDREND+STRIDE] or (ptr-ADDRINIT) % STRIDE != 0, go to ERR with error bit1 set. Otherwise endPtr <= ptr, with ADDREND+STRIDE mapped to ADDRINIT, and go to CHECK.
  - CHECK: rdPtr == endPtr -> DONE, else -> WAIT. Timeout counter cleared.
  - WAIT: o_rqAccess = 1, o_logAddr = rdPtr, both held stable. On i_logDone, latch i_logData (upper N_LOGID_WIDTH bits -> o_entryId, lower bits -> o_entryData) and go to PRESENT. Otherwise increment the counter; on reaching TIMEOUT_CYCLES-1 with no done, go to ERR with error bit0 set.
  - PRESENT: o_entryValid = 1; ID and data held. On i_entryReady: rdPtr <= (rdPtr == ADDREND) ? ADDRINIT : rdPtr + STRIDE, then go to CHECK.
  - DONE: o_done = 1 for one cycle, then IDLE.
  - ERR: terminal until rst; o_busy = 0, o_rqAccess = 0; i_trigger ignored.
- o_busy = 1 in CHECK, WAIT, PRESENT.
- rdPtr persists across scans, so each scan is incremental.
- Timing:
  - Trigger sampled at edge k -> CHECK after k -> WAIT after k+1; o_rqAccess first high in cycle k+2.
  - i_logDone sampled at edge m -> o_entryValid high in cycle m+1.
  - Handshake at edge n -> next request visible in cycle n+2.
  - Empty scan: o_done high in cycle k+2.
- Ignored inputs:
  - i_trigger while busy or in DONE is ignored (not queued).
  - i_logDone outside WAIT is ignored.
  - Changes to i_logAddrptr after the trigger sample do not affect the current scan.
- Wrap: endPtr < rdPtr means the scan crosses ADDREND -> ADDRINIT. Address arithmetic is N_ADDR_WIDTH-bit unsigned.

Test Plan:
- Three-entry scan:
  - Stimulus: rst then release; trigger with i_logAddrptr = 1FEFFC18; memory answers i_logDone 3 cycles after each request; i_entryReady tied 1.
  - Required: requests at 1FEFFC00, 1FEFFC08, 1FEFFC10. First entry is 40'h0300000005 -> o_entryId = 03, o_entryData = 00000005. o_done pulses once; o_rdPtr = 1FEFFC18.
- Empty scan and incremental scan:
  - Trigger again with ptr 1FEFFC18 -> no o_rqAccess, o_done in cycle k+2.
  - Then trigger with 1FEFFC20 -> exactly one request, at 1FEFFC18.
- Wrap-around:
  - Force rdPtr to 1FEFFFF0 via prior scans; trigger with ptr 1FEFFC08.
  - Required: requests at 1FEFFFF0, 1FEFFFF8, 1FEFFC00; final o_rdPtr = 1FEFFC08.
- Backpressure and spurious done:
  - Hold i_entryReady = 0 for 5 cycles: o_entryValid, o_entryId, o_entryData stable, no new request.
  - Extra i_logDone pulses during PRESENT are ignored.
- Timeout:
  - Never assert i_logDone after a request: after 64 WAIT cycles, o_error = 2'b01, o_rqAccess = 0, o_busy = 0.
  - Subsequent triggers are ignored until rst.
- Bad pointer and reset mid-scan:
  - Trigger with ptr 1FEFFC04 -> o_error = 2'b10, no request.
  - Separately, assert rst during WAIT -> next cycle o_rqAccess = 0 and o_rdPtr = 1FEFFC00.
